decode_scoreboard: RTL and testbench

Decode-stage hazard scoreboard for the pipelined processor. Sits directly upstream of the 8x16 register file (`rf_hier`) and drives its `read1regsel`/`read2regsel`. It tracks in-flight writes to each of the 8 architectural registers and stalls the IF/ID stage while any source operand is still pending. Writeback and squash events from later stages retire the pending writes.

---
 rtl/dsb_pkg.sv | 12 +
 rtl/dsb_entry.sv | 50 +++++
 rtl/decode_scoreboard.sv | 106 ++++++++++
 tb/tb_decode_scoreboard.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsb_pkg.sv
// Shared constants and types for the decode-stage hazard scoreboard.
package dsb_pkg;

  localparam int NUM_REGS    = 8;
  localparam int REG_W       = 3;
  localparam int CNT_W       = 2;
  localparam int PEND_MAX    = 3;
  localparam int STALL_CNT_W = 16;

  typedef logic [REG_W-1:0] reg_sel_t;

endpackage

// File: rtl/dsb_entry.sv
// One register's pending-writer counter. Adds one for an issued writer and
// subtracts one each for a writeback and a squash (0..2 per cycle). It clamps
// at 0 on an upstream protocol error and at all-ones instead of wrapping.
module dsb_entry #(
  parameter int CNT_W = dsb_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec_wb,
  input  logic dec_kill,
  output logic busy,
  output logic at_max,
  output logic is_one
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W:0]   up_sum;
  logic [CNT_W:0]   dec_sum;
  logic [CNT_W:0]   diff;

  // Net change for this cycle, with a floor at zero and a ceiling at all-ones.
  always_comb begin
    up_sum  = {1'b0, cnt_reg} + (CNT_W+1)'(inc);
    dec_sum = (CNT_W+1)'(dec_wb) + (CNT_W+1)'(dec_kill);
    diff    = up_sum - dec_sum;
    if (up_sum <= dec_sum) begin
      cnt_next = '0;
    end else if (diff[CNT_W]) begin
      cnt_next = '1;
    end else begin
      cnt_next = diff[CNT_W-1:0];
    end
  end

  // Counter register; reset discards every in-flight writer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign busy   = |cnt_reg;
  assign at_max = &cnt_reg;
  assign is_one = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage hazard scoreboard. It tracks in-flight writers per
// architectural register and stalls IF/ID while a source operand is pending
// or the destination's writer counter is full.
// Optional feature: define DSB_WB_BYPASS_EN to let a consumer issue in the
// same cycle as the writeback of the last pending writer of its source. The
// register file's write-before-read then supplies the value.
module decode_scoreboard #(
  parameter int NUM_REGS = dsb_pkg::NUM_REGS,
  parameter int REG_W    = dsb_pkg::REG_W,
  parameter int CNT_W    = dsb_pkg::CNT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid,
  input  logic [REG_W-1:0]                id_rs,
  input  logic [REG_W-1:0]                id_rt,
  input  logic                            id_rs_used,
  input  logic                            id_rt_used,
  input  logic [REG_W-1:0]                id_rd,
  input  logic                            id_rd_we,
  input  logic                            wb_write,
  input  logic [REG_W-1:0]                wb_regsel,
  input  logic                            kill_valid,
  input  logic [REG_W-1:0]                kill_regsel,
  output logic [REG_W-1:0]                read1regsel,
  output logic [REG_W-1:0]                read2regsel,
  output logic                            stall,
  output logic                            issue,
  output logic [dsb_pkg::STALL_CNT_W-1:0] stall_cycles
);

  import dsb_pkg::*;

`ifdef DSB_WB_BYPASS_EN
  localparam logic WB_BYPASS = 1'b1;
`else
  localparam logic WB_BYPASS = 1'b0;
`endif

  logic [NUM_REGS-1:0] busy_vec;
  logic [NUM_REGS-1:0] at_max_vec;
  logic [NUM_REGS-1:0] is_one_vec;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_wb_vec;
  logic [NUM_REGS-1:0] dec_kill_vec;

  logic haz_s;
  logic haz_t;
  logic full;
  logic bypass_s;
  logic bypass_t;
  logic stall_int;

  logic [STALL_CNT_W-1:0] stall_cycles_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi = gi + 1) begin : g_entry
      assign inc_vec[gi]      = issue & id_rd_we & (id_rd == REG_W'(gi));
      assign dec_wb_vec[gi]   = wb_write & (wb_regsel == REG_W'(gi));
      assign dec_kill_vec[gi] = kill_valid & (kill_regsel == REG_W'(gi));

      dsb_entry #(
        .CNT_W (CNT_W)
      ) u_entry (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc_vec[gi]),
        .dec_wb   (dec_wb_vec[gi]),
        .dec_kill (dec_kill_vec[gi]),
        .busy     (busy_vec[gi]),
        .at_max   (at_max_vec[gi]),
        .is_one   (is_one_vec[gi])
      );
    end
  endgenerate

  // Hazard detection from current counters and this cycle's writeback.
  // A writeback retiring the last pending writer of a source only clears the
  // hazard when the bypass build is selected.
  always_comb begin
    bypass_s  = WB_BYPASS & wb_write & (wb_regsel == id_rs) & is_one_vec[id_rs];
    bypass_t  = WB_BYPASS & wb_write & (wb_regsel == id_rt) & is_one_vec[id_rt];
    haz_s     = id_rs_used & busy_vec[id_rs] & ~bypass_s;
    haz_t     = id_rt_used & busy_vec[id_rt] & ~bypass_t;
    full      = id_rd_we & at_max_vec[id_rd];
    stall_int = ~rst & id_valid & (haz_s | haz_t | full);
  end

  assign stall       = stall_int;
  assign issue       = ~rst & id_valid & ~stall_int;
  assign read1regsel = id_rs;
  assign read2regsel = id_rt;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg <= '0;
    end else if (stall_int && (stall_cycles_reg != '1)) begin
      stall_cycles_reg <= stall_cycles_reg + STALL_CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard. It keeps a behavioural model of
// the pending-writer counts (plain integers) and the stall counter.
`timescale 1ns/1ps
module tb_decode_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_rd_we, wb_write, kill_valid;
  logic [2:0] id_rs, id_rt, id_rd, wb_regsel, kill_regsel;
  logic [2:0] read1regsel, read2regsel;
  logic       stall, issue;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int pend_m[8];
  int sc_m = 0;

`ifdef DSB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #50 clk = ~clk;

  decode_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .id_rd        (id_rd),
    .id_rd_we     (id_rd_we),
    .wb_write     (wb_write),
    .wb_regsel    (wb_regsel),
    .kill_valid   (kill_valid),
    .kill_regsel  (kill_regsel),
    .read1regsel  (read1regsel),
    .read2regsel  (read2regsel),
    .stall        (stall),
    .issue        (issue),
    .stall_cycles (stall_cycles)
  );

  // Reference model: a source is hazardous when it is read and has pending writers.
  function automatic bit src_haz(input bit used, input int r);
    if (!used) return 1'b0;
    if (pend_m[r] == 0) return 1'b0;
    if (BYP && pend_m[r] == 1 && wb_write && int'(wb_regsel) == r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_stall();
    if (rst || !id_valid) return 1'b0;
    return src_haz(id_rs_used, int'(id_rs)) || src_haz(id_rt_used, int'(id_rt)) ||
           (id_rd_we && pend_m[int'(id_rd)] == 3);
  endfunction

  function automatic bit exp_issue();
    return !rst && id_valid && !exp_stall();
  endfunction

  task automatic idle();
    id_valid = 0; id_rs_used = 0; id_rt_used = 0; id_rd_we = 0;
    wb_write = 0; kill_valid = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; wb_regsel = 0; kill_regsel = 0;
  endtask

  // Advance one clock and move the model by the rules for the current inputs.
  task automatic tick();
    int nxt[8];
    bit iss;
    bit stl;
    iss = exp_issue();
    stl = exp_stall();
    for (int r = 0; r < 8; r++) begin
      int v;
      v = pend_m[r];
      if (iss && id_rd_we && int'(id_rd) == r) v = v + 1;
      if (wb_write && int'(wb_regsel) == r) v = v - 1;
      if (kill_valid && int'(kill_regsel) == r) v = v - 1;
      if (v < 0) v = 0;
      if (v > 3) v = 3;
      nxt[r] = rst ? 0 : v;
    end
    @(posedge clk);
    pend_m = nxt;
    if (rst) sc_m = 0;
    else if (stl && sc_m < 65535) sc_m = sc_m + 1;
    #1;
  endtask

  // Combinational look at whether register r has pending writers.
  task automatic probe_pending(input int r, output bit busy);
    logic [20:0] saved;
    saved = {id_valid, id_rs_used, id_rt_used, id_rd_we, wb_write, kill_valid,
             id_rs, id_rt, id_rd, wb_regsel, kill_regsel};
    idle();
    id_valid = 1; id_rs_used = 1; id_rs = 3'(r);
    #1;
    busy = stall;
    {id_valid, id_rs_used, id_rt_used, id_rd_we, wb_write, kill_valid,
     id_rs, id_rt, id_rd, wb_regsel, kill_regsel} = saved;
    #1;
  endtask

  task automatic test_reset();
    bit b;
    rst = 1; idle();
    id_valid = 1; id_rs_used = 1; id_rd_we = 1; wb_write = 1; kill_valid = 1;
    tick(); tick();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL reset_issue: got %b expected 0", issue); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall_cycles: got %0h expected 0", stall_cycles); end
    rst = 0; idle();
    for (int r = 0; r < 8; r++) begin
      probe_pending(r, b);
      checks++; if (b !== 1'b0) begin errors++; $display("FAIL reset_pend r%0d: got busy=%b expected 0", r, b); end
    end
    $display("reset: %0d regs clear", 8);
  endtask

  task automatic test_raw();
    idle(); id_valid = 1; id_rd_we = 1; id_rd = 3;
    #1;
    checks++; if (issue !== exp_issue()) begin errors++; $display("FAIL raw_producer_issue: got %b expected %b", issue, exp_issue()); end
    tick();
    idle(); id_valid = 1; id_rs_used = 1; id_rs = 3; id_rd_we = 1; id_rd = 6;
    #1;
    checks++; if (stall !== exp_stall() || stall !== 1'b1) begin errors++; $display("FAIL raw_consumer_stall: got %b expected 1", stall); end
    tick();
    wb_write = 1; wb_regsel = 3;
    #1;
    checks++; if (issue !== exp_issue()) begin errors++; $display("FAIL raw_wb_cycle_issue: got %b expected %b", issue, exp_issue()); end
    checks++; if (read1regsel !== 3'd3) begin errors++; $display("FAIL raw_read1regsel: got %0d expected 3", read1regsel); end
    tick();
    wb_write = 0;
    #1;
    checks++; if (issue !== exp_issue() || issue !== 1'b1) begin errors++; $display("FAIL raw_after_wb_issue: got %b expected 1", issue); end
    tick();
    idle(); wb_write = 1; wb_regsel = 6; tick();
    tick(); tick();
    idle();
    $display("raw: r3 producer/consumer, bypass=%0d", BYP);
  endtask

  task automatic test_saturation();
    idle();
    for (int i = 0; i < 3; i++) begin
      id_valid = 1; id_rd_we = 1; id_rd = 5;
      #1;
      checks++; if (issue !== exp_issue() || issue !== 1'b1) begin errors++; $display("FAIL sat_writer%0d_issue: got %b expected 1", i, issue); end
      tick();
    end
    #1;
    checks++; if (stall !== exp_stall() || stall !== 1'b1) begin errors++; $display("FAIL sat_full_stall: got %b expected 1", stall); end
    wb_write = 1; wb_regsel = 5;
    #1;
    checks++; if (stall !== exp_stall() || stall !== 1'b1) begin errors++; $display("FAIL sat_full_with_wb: got %b expected 1", stall); end
    tick();
    wb_write = 0;
    #1;
    checks++; if (issue !== exp_issue() || issue !== 1'b1) begin errors++; $display("FAIL sat_after_wb_issue: got %b expected 1", issue); end
    tick();
    idle(); wb_write = 1; wb_regsel = 5;
    tick(); tick(); tick();
    idle();
    $display("saturation: r5 full then released");
  endtask

  task automatic test_simultaneous();
    bit b;
    idle(); id_valid = 1; id_rd_we = 1; id_rd = 2; tick();
    wb_write = 1; wb_regsel = 2;
    #1;
    checks++; if (issue !== exp_issue()) begin errors++; $display("FAIL simul_inc_dec_issue: got %b expected %b", issue, exp_issue()); end
    tick();
    idle();
    probe_pending(2, b);
    checks++; if (b !== (pend_m[2] != 0)) begin errors++; $display("FAIL simul_pend_kept: got busy=%b expected %b", b, pend_m[2] != 0); end
    wb_write = 1; wb_regsel = 2; tick(); idle();
    probe_pending(2, b);
    checks++; if (b !== (pend_m[2] != 0)) begin errors++; $display("FAIL simul_pend_one: got busy=%b expected %b", b, pend_m[2] != 0); end
    id_valid = 1; id_rd_we = 1; id_rd = 2; tick(); tick();
    idle(); wb_write = 1; wb_regsel = 2; kill_valid = 1; kill_regsel = 2; tick(); idle();
    probe_pending(2, b);
    checks++; if (b !== (pend_m[2] != 0)) begin errors++; $display("FAIL simul_wb_kill: got busy=%b expected %b", b, pend_m[2] != 0); end
    $display("simultaneous: r2 inc/dec and wb+kill");
  endtask

  task automatic test_unused();
    idle(); id_valid = 1; id_rd_we = 1; id_rd = 4; tick(); tick();
    idle(); id_valid = 1; id_rs = 4; id_rt = 4;
    #1;
    checks++; if (stall !== exp_stall() || stall !== 1'b0) begin errors++; $display("FAIL unused_rs_stall: got %b expected 0", stall); end
    checks++; if (issue !== exp_issue()) begin errors++; $display("FAIL unused_rs_issue: got %b expected %b", issue, exp_issue()); end
    id_rs_used = 1;
    #1;
    checks++; if (stall !== exp_stall() || stall !== 1'b1) begin errors++; $display("FAIL used_rs_stall: got %b expected 1", stall); end
    idle(); wb_write = 1; wb_regsel = 4; kill_valid = 1; kill_regsel = 4; tick(); idle();
    $display("unused: rs=r4 with pend 2");
  endtask

  task automatic test_underflow();
    bit b;
    idle(); wb_write = 1; wb_regsel = 6; kill_valid = 1; kill_regsel = 6; tick();
    idle(); id_valid = 1; id_rd_we = 1; id_rd = 6;
    #1;
    checks++; if (issue !== exp_issue() || issue !== 1'b1) begin errors++; $display("FAIL underflow_issue: got %b expected 1", issue); end
    tick(); idle();
    probe_pending(6, b);
    checks++; if (b !== (pend_m[6] != 0)) begin errors++; $display("FAIL underflow_one: got busy=%b expected %b", b, pend_m[6] != 0); end
    wb_write = 1; wb_regsel = 6; tick(); idle();
    probe_pending(6, b);
    checks++; if (b !== (pend_m[6] != 0)) begin errors++; $display("FAIL underflow_zero: got busy=%b expected %b", b, pend_m[6] != 0); end
    $display("underflow: r6 floor at zero");
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      id_valid    = $urandom_range(0, 1);
      id_rs_used  = $urandom_range(0, 1);
      id_rt_used  = $urandom_range(0, 1);
      id_rd_we    = $urandom_range(0, 1);
      wb_write    = $urandom_range(0, 1);
      kill_valid  = ($urandom_range(0, 3) == 0);
      id_rs       = 3'($urandom_range(0, 7));
      id_rt       = 3'($urandom_range(0, 7));
      id_rd       = 3'($urandom_range(0, 7));
      wb_regsel   = 3'($urandom_range(0, 7));
      kill_regsel = 3'($urandom_range(0, 7));
      #1;
      checks++; if (stall !== exp_stall()) begin errors++; bad++; $display("FAIL rand_stall cyc%0d: got %b expected %b", i, stall, exp_stall()); end
      checks++; if (issue !== exp_issue()) begin errors++; bad++; $display("FAIL rand_issue cyc%0d: got %b expected %b", i, issue, exp_issue()); end
      checks++; if (read1regsel !== id_rs || read2regsel !== id_rt) begin errors++; bad++; $display("FAIL rand_regsel cyc%0d: got %0d/%0d expected %0d/%0d", i, read1regsel, read2regsel, id_rs, id_rt); end
      checks++; if (int'(stall_cycles) !== sc_m) begin errors++; bad++; $display("FAIL rand_stall_cycles cyc%0d: got %0d expected %0d", i, stall_cycles, sc_m); end
      tick();
    end
    rst = 0; idle();
    $display("random: 400 cycles, %0d mismatching checks", bad);
  endtask

  task automatic test_counter();
    rst = 1; idle(); tick(); rst = 0;
    id_valid = 1; id_rd_we = 1; id_rd = 1; tick();
    idle(); id_valid = 1; id_rs_used = 1; id_rs = 1;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (i == 999) begin
        checks++; if (int'(stall_cycles) !== sc_m) begin errors++; $display("FAIL counter_mid: got %0d expected %0d", stall_cycles, sc_m); end
      end
    end
    checks++; if (int'(stall_cycles) !== sc_m || stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL counter_saturate: got %0h expected ffff", stall_cycles); end
    rst = 1; idle(); tick();
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL counter_reset: got %0h expected 0", stall_cycles); end
    rst = 0;
    $display("counter: stall_cycles=%0h after 70000 stalls", 16'hFFFF);
  endtask

  initial begin
    for (int r = 0; r < 8; r++) pend_m[r] = 0;
    rst = 1;
    idle();
    test_reset();
    test_raw();
    test_saturation();
    test_simultaneous();
    test_unused();
    test_underflow();
    test_random();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
